// File: rtl/tt_vpu_ovi_issue_ctrl.sv
// Scalar-side OVI sequencer: scoreboard-ID allocation, issue credits, in-order
// commit/kill dispatch, completion retirement and memop sync-window tracking.
module tt_vpu_ovi_issue_ctrl #(
  parameter  int NUM_SB        = 32,
  parameter  int ISSUE_CREDITS = 16,
  parameter  int MEM_CNT_W     = 6,
  localparam int SB_W          = $clog2(NUM_SB)
) (
  input  logic                 clk,
  input  logic                 reset,
  // core request side
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_inst,
  input  logic [63:0]          req_scalar_opnd,
  output logic [SB_W-1:0]      req_sb_id,
  // OVI issue
  output logic                 issue_valid,
  output logic [31:0]          issue_inst,
  output logic [63:0]          issue_scalar_opnd,
  output logic [SB_W-1:0]      issue_sb_id,
  input  logic                 issue_credit,
  // commit / kill decisions and OVI dispatch
  input  logic                 commit_valid,
  input  logic                 kill_valid,
  output logic                 dispatch_next_senior,
  output logic                 dispatch_kill,
  output logic [SB_W-1:0]      dispatch_sb_id,
  // completion
  input  logic                 completed_valid,
  input  logic [SB_W-1:0]      completed_sb_id,
  output logic                 retire_valid,
  output logic [SB_W-1:0]      retire_sb_id,
  // memop sync windows
  input  logic                 memop_sync_start,
  input  logic                 memop_sync_end,
  output logic [MEM_CNT_W-1:0] mem_pending,
  output logic [3:0]           err
);

  typedef enum logic [1:0] {
    SB_FREE   = 2'd0,
    SB_ISSUED = 2'd1,
    SB_SENIOR = 2'd2
  } sb_state_e;

  localparam logic [4:0]      CREDIT_MAX = 5'(ISSUE_CREDITS);
  localparam logic [SB_W-1:0] PTR_LAST   = SB_W'(NUM_SB - 1);

  // Scoreboard state
  sb_state_e st_q [NUM_SB];
  sb_state_e st_d [NUM_SB];

  // Order FIFO
  logic [SB_W-1:0] fifo_mem [NUM_SB];
  logic [SB_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SB_W-1:0] wr_ptr_q, wr_ptr_d;
  logic            full_q, full_d;

  // Counters and flags
  logic [4:0]           credit_q, credit_d;
  logic [MEM_CNT_W-1:0] mem_q, mem_d;
  logic [3:0]           err_q, err_d;

  // Registered outputs
  logic            issue_valid_q, issue_valid_d;
  logic [31:0]     issue_inst_q, issue_inst_d;
  logic [63:0]     issue_opnd_q, issue_opnd_d;
  logic [SB_W-1:0] issue_sb_q, issue_sb_d;
  logic            disp_senior_q, disp_senior_d;
  logic            disp_kill_q, disp_kill_d;
  logic [SB_W-1:0] disp_sb_q, disp_sb_d;
  logic            retire_valid_q, retire_valid_d;
  logic [SB_W-1:0] retire_sb_q, retire_sb_d;

  // Combinational helpers
  logic            any_free;
  logic [SB_W-1:0] alloc_id;
  logic            fifo_empty;
  logic [SB_W-1:0] fifo_head;
  logic            accept;
  logic            pop_req;
  logic            pop_ok;
  logic            comp_ok;
  logic [5:0]      credit_sum;

  function automatic logic [SB_W-1:0] ptr_inc(input logic [SB_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Lowest-index FREE entry; scanning downward lets the lowest match win.
  always_comb begin
    any_free = 1'b0;
    alloc_id = '0;
    for (int i = NUM_SB - 1; i >= 0; i--) begin
      if (st_q[i] == SB_FREE) begin
        any_free = 1'b1;
        alloc_id = SB_W'(i);
      end
    end
  end

  assign fifo_empty = !full_q && (rd_ptr_q == wr_ptr_q);
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign req_ready  = (credit_q != 5'd0) && any_free && !full_q;
  assign req_sb_id  = alloc_id;
  assign accept     = req_valid && req_ready;
  assign pop_req    = commit_valid || kill_valid;
  assign pop_ok     = pop_req && !fifo_empty;
  assign comp_ok    = completed_valid && (st_q[completed_sb_id] == SB_SENIOR);
  assign credit_sum = {1'b0, credit_q} - {5'd0, accept} + {5'd0, issue_credit};

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    st_d           = st_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    full_d         = full_q;
    credit_d       = credit_q;
    mem_d          = mem_q;
    err_d          = err_q;
    issue_valid_d  = accept;
    issue_inst_d   = issue_inst_q;
    issue_opnd_d   = issue_opnd_q;
    issue_sb_d     = issue_sb_q;
    disp_senior_d  = 1'b0;
    disp_kill_d    = 1'b0;
    disp_sb_d      = disp_sb_q;
    retire_valid_d = comp_ok;
    retire_sb_d    = retire_sb_q;

    // Completion, pop and accept always touch distinct entries: they act on
    // SENIOR, ISSUED (FIFO head) and FREE entries respectively.
    if (comp_ok) begin
      st_d[completed_sb_id] = SB_FREE;
      retire_sb_d           = completed_sb_id;
    end else if (completed_valid) begin
      err_d[1] = 1'b1;
    end

    if (pop_req && (fifo_empty || (commit_valid && kill_valid))) begin
      err_d[2] = 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d  = ptr_inc(rd_ptr_q);
      disp_sb_d = fifo_head;
      if (kill_valid) begin
        st_d[fifo_head] = SB_FREE;
        disp_kill_d     = 1'b1;
      end else begin
        st_d[fifo_head] = SB_SENIOR;
        disp_senior_d   = 1'b1;
      end
    end

    if (accept) begin
      st_d[alloc_id] = SB_ISSUED;
      wr_ptr_d       = ptr_inc(wr_ptr_q);
      issue_inst_d   = req_inst;
      issue_opnd_d   = req_scalar_opnd;
      issue_sb_d     = alloc_id;
    end

    if (accept && !pop_ok) begin
      full_d = (ptr_inc(wr_ptr_q) == rd_ptr_q);
    end else if (pop_ok && !accept) begin
      full_d = 1'b0;
    end

    if (credit_sum > {1'b0, CREDIT_MAX}) begin
      credit_d = CREDIT_MAX;
      err_d[0] = 1'b1;
    end else begin
      credit_d = credit_sum[4:0];
    end

    if (memop_sync_start && !memop_sync_end) begin
      if (&mem_q) err_d[3] = 1'b1;
      else        mem_d    = mem_q + 1'b1;
    end else if (memop_sync_end && !memop_sync_start) begin
      if (mem_q == '0) err_d[3] = 1'b1;
      else             mem_d    = mem_q - 1'b1;
    end
  end

  // NOTE: the FIFO storage is not reset; only pointers and the full bit
  // define its contents, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr_q] <= alloc_id;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SB; i++) st_q[i] <= SB_FREE;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      full_q         <= 1'b0;
      credit_q       <= CREDIT_MAX;
      mem_q          <= '0;
      err_q          <= '0;
      issue_valid_q  <= 1'b0;
      issue_inst_q   <= '0;
      issue_opnd_q   <= '0;
      issue_sb_q     <= '0;
      disp_senior_q  <= 1'b0;
      disp_kill_q    <= 1'b0;
      disp_sb_q      <= '0;
      retire_valid_q <= 1'b0;
      retire_sb_q    <= '0;
    end else begin
      st_q           <= st_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      full_q         <= full_d;
      credit_q       <= credit_d;
      mem_q          <= mem_d;
      err_q          <= err_d;
      issue_valid_q  <= issue_valid_d;
      issue_inst_q   <= issue_inst_d;
      issue_opnd_q   <= issue_opnd_d;
      issue_sb_q     <= issue_sb_d;
      disp_senior_q  <= disp_senior_d;
      disp_kill_q    <= disp_kill_d;
      disp_sb_q      <= disp_sb_d;
      retire_valid_q <= retire_valid_d;
      retire_sb_q    <= retire_sb_d;
    end
  end

  assign issue_valid          = issue_valid_q;
  assign issue_inst           = issue_inst_q;
  assign issue_scalar_opnd    = issue_opnd_q;
  assign issue_sb_id          = issue_sb_q;
  assign dispatch_next_senior = disp_senior_q;
  assign dispatch_kill        = disp_kill_q;
  assign dispatch_sb_id       = disp_sb_q;
  assign retire_valid         = retire_valid_q;
  assign retire_sb_id         = retire_sb_q;
  assign mem_pending          = mem_q;
  assign err                  = err_q;

endmodule
